// File: rtl/noc_credit_return.sv
// Router input-port flit buffer with one-for-one credit return to the upstream router.
// Show-ahead FIFO: the head flit is presented combinationally from storage while non-empty.
module noc_credit_return #(
  parameter int unsigned FLIT_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flit_valid_i,
  input  logic [FLIT_W-1:0]        flit_i,
  input  logic                     flit_rd_i,
  output logic                     flit_valid_o,
  output logic [FLIT_W-1:0]        flit_o,
  output logic                     credit_incr_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              credit_q;
  logic              ovf_q, ovf_d;
  logic              empty, full, rd_fire, wr_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign rd_fire = flit_rd_i & ~empty;
  // A read in the same cycle frees the slot, so a write at full is still accepted.
  assign wr_fire = flit_valid_i & (~full | rd_fire);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(wr_fire) - CW'(rd_fire);
    ovf_d    = ovf_q | (flit_valid_i & ~wr_fire);
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= rd_fire;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; stale contents are masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= flit_i;
  end

  assign flit_valid_o   = ~empty;
  assign full_o         = full;
  assign count_o        = count_q;
  assign credit_incr_o  = credit_q;
  assign overflow_err_o = ovf_q;
  assign flit_o         = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_noc_credit_return.sv
// Randomized and directed bench for noc_credit_return against a queue-based buffer model
// that also tracks the upstream credit counter.
module tb_noc_credit_return;

  localparam int FLIT_W = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flit_valid_i = 1'b0;
  logic [FLIT_W-1:0] flit_i = '0;
  logic              flit_rd_i = 1'b0;
  logic              flit_valid_o;
  logic [FLIT_W-1:0] flit_o;
  logic              credit_incr_o;
  logic              full_o;
  logic [CW-1:0]     count_o;
  logic              overflow_err_o;

  noc_credit_return #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .flit_valid_i(flit_valid_i),
    .flit_i(flit_i),
    .flit_rd_i(flit_rd_i),
    .flit_valid_o(flit_valid_o),
    .flit_o(flit_o),
    .credit_incr_o(credit_incr_o),
    .full_o(full_o),
    .count_o(count_o),
    .overflow_err_o(overflow_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: buffered flits in arrival order, expected pulse/flag, upstream credits.
  logic [FLIT_W-1:0] model_q[$];
  bit exp_credit;
  bit exp_ovf;
  int up_credits;
  bit inv_en;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [FLIT_W-1:0] exp_head;
    exp_head = (model_q.size() > 0) ? model_q[0] : '0;
    check_eq("flit_valid", 64'(flit_valid_o), 64'(model_q.size() > 0));
    check_eq("flit_data", 64'(flit_o), 64'(exp_head));
    check_eq("count", 64'(count_o), 64'(model_q.size()));
    check_eq("full", 64'(full_o), 64'(model_q.size() == DEPTH));
    check_eq("credit", 64'(credit_incr_o), 64'(exp_credit));
    check_eq("overflow", 64'(overflow_err_o), 64'(exp_ovf));
  endtask

  // Called at posedge+1; drives one cycle of inputs and checks after the next edge.
  task automatic step(input bit v, input logic [FLIT_W-1:0] d, input bit rd);
    bit rd_ok, wr_ok, prev_credit;
    flit_valid_i = v;
    flit_i       = d;
    flit_rd_i    = rd;
    prev_credit  = credit_incr_o;
    @(posedge clk);
    #1;
    rd_ok = rd && (model_q.size() > 0);
    wr_ok = v && ((model_q.size() < DEPTH) || rd_ok);
    if (v && !wr_ok) exp_ovf = 1'b1;
    if (rd_ok) void'(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    exp_credit = rd_ok;
    up_credits = up_credits - int'(v) + int'(prev_credit);
    $display("TXN t=%0t wr=%0b rd=%0b data=%08h head=%08h cnt=%0d credit=%0b ovf=%0b",
             $time, v, rd, d, flit_o, count_o, credit_incr_o, overflow_err_o);
    check_outputs();
    if (inv_en)
      check_eq("credit_sum", 64'(up_credits + int'(count_o) + int'(credit_incr_o)), 64'(DEPTH));
  endtask

  task automatic do_reset();
    flit_valid_i = 1'b0;
    flit_rd_i    = 1'b0;
    flit_i       = '0;
    rst_n        = 1'b0;
    #1;
    model_q.delete();
    exp_credit = 1'b0;
    exp_ovf    = 1'b0;
    up_credits = DEPTH;
    $display("TXN t=%0t reset cnt=%0d credit=%0b", $time, count_o, credit_incr_o);
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    inv_en = 1'b0;
    do_reset();

    // First write visible after one edge, no credit.
    step(1'b1, 32'hA1A1_0001, 1'b0);
    // Fill to full, then an overflowing write that must be dropped.
    step(1'b1, 32'hA1A1_0002, 1'b0);
    step(1'b1, 32'hA1A1_0003, 1'b0);
    step(1'b1, 32'hA1A1_0004, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, '0, 1'b0);

    // Full buffer, simultaneous write and read.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hB000_0000 + i, 1'b0);
    step(1'b1, 32'hB000_0010, 1'b1);
    step(1'b0, '0, 1'b0);
    // Drain with back-to-back reads, then an idle cycle and a read on empty.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Reset in the cycle right after a read, then stream 10 flits across wrap.
    step(1'b1, 32'hC000_0001, 1'b0);
    step(1'b1, 32'hC000_0002, 1'b0);
    step(1'b0, '0, 1'b1);
    do_reset();
    inv_en = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 32'hE000_0000 + i, i >= 2);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    inv_en = 1'b0;

    // Random traffic ignoring credits (exercises overflow).
    for (int i = 0; i < 150; i++)
      step(1'(($urandom % 4) != 0), $urandom, 1'($urandom % 2));

    // Random traffic from a credit-respecting sender.
    do_reset();
    inv_en = 1'b1;
    for (int i = 0; i < 200; i++)
      step(1'((up_credits > 0) && (($urandom % 4) != 0)), $urandom, 1'(($urandom % 3) == 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
